fpu_vector_driver: RTL and testbench

FPU_VECTOR_DRIVER -- requirements
Module: fpu_vector_driver

---
 rtl/fpu_vector_driver.sv | 145 ++++++++++++++
 tb/tb_fpu_vector_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_vector_driver.sv
// Replays a small vector memory into an external FPU, waits a fixed latency per vector,
// and compares the returned result against the stored expected value.
module fpu_vector_driver #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 5,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [31:0]   wr_a,
  input  logic [31:0]   wr_b,
  input  logic [1:0]    wr_op,
  input  logic [31:0]   wr_exp,
  input  logic [NW-1:0] num_vec,
  input  logic          start,
  input  logic [31:0]   outp,
  output logic [31:0]   A,
  output logic [31:0]   B,
  output logic [1:0]    opcode,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [NW-1:0] err_count,
  output logic          fail_valid,
  output logic [IW-1:0] fail_idx,
  output logic [31:0]   fail_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem_a   [DEPTH];
  logic [31:0] mem_b   [DEPTH];
  logic [1:0]  mem_op  [DEPTH];
  logic [31:0] mem_exp [DEPTH];

  logic [IW-1:0] idx;
  logic [NW-1:0] nv_q;
  logic [NW-1:0] nv_in;
  logic [3:0]    wcnt;
  logic          last;
  logic          mism;
  logic          wr_ok;

  // Oversized run requests are clamped to the memory size.
  assign nv_in = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
  assign last  = (NW'(idx) == nv_q - NW'(1));
  assign mism  = (outp != mem_exp[idx]);
  assign wr_ok = !rst && wr_en && !busy && ({{(32-IW){1'b0}}, wr_addr} < 32'(DEPTH));

  // Vector memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_a[wr_addr]   <= wr_a;
      mem_b[wr_addr]   <= wr_b;
      mem_op[wr_addr]  <= wr_op;
      mem_exp[wr_addr] <= wr_exp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (nv_in == '0) ? S_DONE : S_DRIVE;
      S_DRIVE:        state_nxt = S_WAIT;
      S_WAIT:         if (wcnt == 4'(LATENCY - 1)) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = last ? S_DONE : S_DRIVE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      S_DRIVE, S_WAIT, S_CHECK: busy = 1'b1;
      S_DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A          <= '0;
      B          <= '0;
      opcode     <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      fail_out   <= '0;
      idx        <= '0;
      wcnt       <= '0;
      nv_q       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            nv_q       <= nv_in;
            idx        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_out   <= '0;
          end
        end
        S_DRIVE: begin
          A      <= mem_a[idx];
          B      <= mem_b[idx];
          opcode <= mem_op[idx];
          wcnt   <= '0;
        end
        S_WAIT: wcnt <= wcnt + 4'd1;
        // Only the first mismatch is captured; later ones only bump the count.
        S_CHECK: begin
          if (mism) begin
            err_count <= err_count + NW'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
              fail_out   <= outp;
            end
          end
          if (!last) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_vector_driver.sv
// Scoreboard bench for fpu_vector_driver: stimulus pushes expected run results,
// a monitor pops them on each done rising edge and also tracks the driven operands.
module tb_fpu_vector_driver;
  localparam int DEPTH = 8;
  localparam int LAT   = 5;
  localparam int PER   = LAT + 2;

  logic        clk = 1'b0;
  logic        rst, wr_en, start;
  logic [2:0]  wr_addr;
  logic [31:0] wr_a, wr_b, wr_exp, outp;
  logic [1:0]  wr_op;
  logic [3:0]  num_vec;
  logic [31:0] A, B, fail_out;
  logic [1:0]  opcode;
  logic        busy, done, pass, fail_valid;
  logic [3:0]  err_count;
  logic [2:0]  fail_idx;

  always #5 clk = ~clk;

  fpu_vector_driver #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .wr_op(wr_op), .wr_exp(wr_exp), .num_vec(num_vec), .start(start), .outp(outp),
    .A(A), .B(B), .opcode(opcode), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_out(fail_out)
  );

  // Stand-in FPU: a pure function of the operands, optionally overridden.
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return {a[15:0], b[31:16]};
    endcase
  endfunction

  logic        ovr_en = 1'b0;
  logic [31:0] ovr = '0;
  assign outp = ovr_en ? ovr : fpu_fn(A, B, opcode);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory image and per-run snapshot.
  logic [31:0] ma [DEPTH];
  logic [31:0] mb [DEPTH];
  logic [1:0]  mop [DEPTH];
  logic [31:0] mexp [DEPTH];
  logic [31:0] ra [DEPTH];
  logic [31:0] rb [DEPTH];
  logic [1:0]  rop [DEPTH];
  int          run_c = 0;
  int          run_n = 0;
  bit          run_active = 1'b0;

  typedef struct {
    int          lat;
    int          n;
    logic [31:0] err;
    logic        pss;
    logic        fv;
    logic [2:0]  fidx;
    logic [31:0] fout;
    logic [31:0] la;
    logic [31:0] lb;
    logic [1:0]  lop;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Monitor: operand stability while busy, and result check on each done rising edge.
  initial begin
    logic dq;
    dq = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (run_active && busy) begin
        int k, v;
        k = cyc - run_c;
        if (k >= 2 && k <= run_n * PER) begin
          v = (k - 2) / PER;
          chk("opA", A, ra[v]);
          chk("opB", B, rb[v]);
          chk("opcode", {30'd0, opcode}, {30'd0, rop[v]});
        end
      end
      if (done && !dq) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no pending run");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("latency", cyc - run_c, e.lat);
          chk("err_count", {28'd0, err_count}, e.err);
          chk("pass", {31'd0, pass}, {31'd0, e.pss});
          chk("fail_valid", {31'd0, fail_valid}, {31'd0, e.fv});
          chk("fail_idx", {29'd0, fail_idx}, {29'd0, e.fidx});
          chk("fail_out", fail_out, e.fout);
          chk("busy_done", {31'd0, busy}, 32'd0);
          if (e.n > 0) begin
            chk("hold_A", A, e.la);
            chk("hold_B", B, e.lb);
          end
        end
      end
      dq = done;
    end
  end

  task automatic wr(input logic [2:0] ad, input logic [31:0] a, input logic [31:0] b,
                    input logic [1:0] op, input logic [31:0] ex);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = ad; wr_a = a; wr_b = b; wr_op = op; wr_exp = ex;
    ma[ad] = a; mb[ad] = b; mop[ad] = op; mexp[ad] = ex;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_vecs(input logic [7:0] badmask);
    for (int v = 0; v < DEPTH; v++) begin
      logic [31:0] a, b, r;
      logic [1:0]  op;
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(0, 3));
      r  = fpu_fn(a, b, op);
      if (badmask[v]) r = r ^ (32'h1 << $urandom_range(0, 31));
      wr(3'(v), a, b, op, r);
    end
  endtask

  task automatic begin_run(input int n, input bit push);
    exp_t e;
    int   ne;
    ne     = (n > DEPTH) ? DEPTH : n;
    e.n    = ne;
    e.lat  = ne * PER + 1;
    e.err  = 0;
    e.fv   = 1'b0;
    e.fidx = '0;
    e.fout = '0;
    e.la   = '0;
    e.lb   = '0;
    e.lop  = '0;
    for (int v = 0; v < ne; v++) begin
      logic [31:0] o;
      o = ovr_en ? ovr : fpu_fn(ma[v], mb[v], mop[v]);
      if (o != mexp[v]) begin
        e.err++;
        if (!e.fv) begin
          e.fv = 1'b1; e.fidx = 3'(v); e.fout = o;
        end
      end
    end
    e.pss = (e.err == 0);
    if (ne > 0) begin
      e.la = ma[ne-1]; e.lb = mb[ne-1]; e.lop = mop[ne-1];
    end
    if (push) sbq.push_back(e);
    ra = ma; rb = mb; rop = mop;
    run_n = ne;
    @(negedge clk);
    num_vec = 4'(n);
    start = 1'b1;
    run_c = cyc;
    run_active = (ne > 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sb(input bit collide);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
      if (collide && t == 10) begin
        start = 1'b1; num_vec = 4'd1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_a = $urandom; wr_b = $urandom;
        wr_op = 2'd3; wr_exp = $urandom;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got pending=%0d want 0", sbq.size());
      sbq.delete();
    end
    run_active = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A"}, A, 32'd0);
    chk({tag, "_B"}, B, 32'd0);
    chk({tag, "_opcode"}, {30'd0, opcode}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_err"}, {28'd0, err_count}, 32'd0);
    chk({tag, "_fv"}, {31'd0, fail_valid}, 32'd0);
    chk({tag, "_fidx"}, {29'd0, fail_idx}, 32'd0);
    chk({tag, "_fout"}, fail_out, 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    wr_op = '0; wr_exp = '0; num_vec = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // num_vec = 0 from IDLE: done next cycle with pass
    begin_run(0, 1'b1);
    wait_sb(1'b0);

    // Known single vector, FPU returns the expected and then a wrong value
    wr(3'd0, 32'h3F49FC44, 32'h3F43A91D, 2'd0, 32'h3FC6D2B0);
    ovr_en = 1'b1;
    ovr = 32'h3FC6D2B0;
    begin_run(1, 1'b1);
    wait_sb(1'b0);
    ovr = 32'h3FC6D2B1;
    begin_run(1, 1'b1);
    wait_sb(1'b0);
    ovr_en = 1'b0;

    // Full run with vectors 2 and 5 wrong, then an oversized request
    load_vecs(8'b0010_0100);
    begin_run(8, 1'b1);
    wait_sb(1'b0);
    begin_run(12, 1'b1);
    wait_sb(1'b0);

    // Mid-run start and write are ignored; a rerun sees unchanged memory
    begin_run(8, 1'b1);
    wait_sb(1'b1);
    begin_run(8, 1'b1);
    wait_sb(1'b0);

    // Reset in the WAIT of vector 3, with start and a write also asserted
    begin_run(8, 1'b0);
    while (cyc < run_c + 3 * PER + 3) @(negedge clk);
    run_active = 1'b0;
    rst = 1'b1; start = 1'b1; num_vec = 4'd8;
    wr_en = 1'b1; wr_addr = 3'd4; wr_a = $urandom; wr_b = $urandom; wr_exp = $urandom;
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0; start = 1'b0; wr_en = 1'b0;
    begin_run(8, 1'b1);
    wait_sb(1'b0);

    // Randomized vectors, error patterns and run lengths
    for (int i = 0; i < 6; i++) begin
      load_vecs(8'($urandom_range(0, 255)));
      begin_run($urandom_range(1, 12), 1'b1);
      wait_sb(1'b0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got time=%0t want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
